ibex_instr_compressor: RTL

IBEX_INSTR_COMPRESSOR -- requirements
Module: ibex_instr_compressor

---
 rtl/ibex_instr_compressor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_instr_compressor.sv
// ibex_instr_compressor
// Rewrites a stream of RV32I instructions into RVC form where a standard
// 16-bit encoding exists and packs the resulting halfwords into 32-bit words.
// A single residue halfword carries odd halfwords over to the next word; the
// end of a stream is padded with c.nop (0x0001) so no halfword is left behind.
module ibex_instr_compressor #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_instr_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_word_o,
  output logic [CntWidth-1:0] cmp_count_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [15:0]         CNop   = 16'h0001;

  // Registered state and its next-state values
  state_e              state_q, state_d;
  logic [15:0]         res_q, res_d;
  logic                res_v_q, res_v_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_word_q, out_word_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Handshakes
  logic accept;
  logic take;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr_i[6:0];
  assign rd     = in_instr_i[11:7];
  assign funct3 = in_instr_i[14:12];
  assign rs1    = in_instr_i[19:15];
  assign rs2    = in_instr_i[24:20];
  assign funct7 = in_instr_i[31:25];

  logic is_addi, is_add, is_lw, is_sw, is_jalr;
  logic imm_small;   // I-immediate fits the signed 6-bit CI field
  logic imm_zero;    // I-immediate is zero
  logic lw_off_ok;   // load offset in 0..124, word aligned
  logic sw_off_ok;   // store offset in 0..124, word aligned
  logic rd_c, rs1_c, rs2_c;  // register is one of x8..x15

  assign is_addi   = (opcode == 7'h13) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'h33) && (funct3 == 3'b000) && (funct7 == 7'h00);
  assign is_lw     = (opcode == 7'h03) && (funct3 == 3'b010);
  assign is_sw     = (opcode == 7'h23) && (funct3 == 3'b010);
  assign is_jalr   = (opcode == 7'h67) && (funct3 == 3'b000);
  assign imm_small = (funct7 == {7{in_instr_i[25]}});
  assign imm_zero  = (in_instr_i[31:20] == 12'h000);
  assign lw_off_ok = (in_instr_i[31:27] == 5'b0) && (in_instr_i[21:20] == 2'b00);
  assign sw_off_ok = (in_instr_i[31:27] == 5'b0) && (in_instr_i[8:7] == 2'b00);
  assign rd_c      = (rd[4:3]  == 2'b01);
  assign rs1_c     = (rs1[4:3] == 2'b01);
  assign rs2_c     = (rs2[4:3] == 2'b01);

  logic        comp;  // offered instruction has an RVC form
  logic [15:0] cval;  // that RVC form

  // Compression decoder, first matching rule wins
  always_comb begin
    // NOTE: defaults first so every path assigns comp/cval and no latch is inferred.
    comp = 1'b0;
    cval = 16'h0000;
    if (in_instr_i == 32'h0000_0013) begin
      comp = 1'b1;
      cval = CNop;
    end else if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm_small) begin
      comp = 1'b1;  // c.li
      cval = {3'b010, in_instr_i[25], rd, in_instr_i[24:20], 2'b01};
    end else if (is_addi && (rs1 == rd) && (rd != 5'd0) && !imm_zero && imm_small) begin
      comp = 1'b1;  // c.addi
      cval = {3'b000, in_instr_i[25], rd, in_instr_i[24:20], 2'b01};
    end else if (is_add && (rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
      comp = 1'b1;  // c.mv
      cval = {4'b1000, rd, rs2, 2'b10};
    end else if (is_add && (rs1 == rd) && (rd != 5'd0) && (rs2 != 5'd0)) begin
      comp = 1'b1;  // c.add
      cval = {4'b1001, rd, rs2, 2'b10};
    end else if (is_lw && rd_c && rs1_c && lw_off_ok) begin
      comp = 1'b1;  // c.lw: offset bits [5:3], [2], [6]
      cval = {3'b010, in_instr_i[25:23], rs1[2:0], in_instr_i[22], in_instr_i[26],
              rd[2:0], 2'b00};
    end else if (is_sw && rs2_c && rs1_c && sw_off_ok) begin
      comp = 1'b1;  // c.sw: offset bits [5:3], [2], [6]
      cval = {3'b110, in_instr_i[25], in_instr_i[11:10], rs1[2:0], in_instr_i[9],
              in_instr_i[26], rs2[2:0], 2'b00};
    end else if (is_jalr && (rd == 5'd0) && imm_zero && (rs1 != 5'd0)) begin
      comp = 1'b1;  // c.jr
      cval = {4'b1000, rs1, 5'd0, 2'b10};
    end else if (in_instr_i == 32'h0010_0073) begin
      comp = 1'b1;  // c.ebreak
      cval = 16'h9002;
    end
  end

  assign in_ready_o = !rst_i && (state_q == RUN) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign take       = out_valid_q && out_ready_i;

  // Next-state logic: residue packing, output stage and FLUSH sequencing
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_v_d     = res_v_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_word_d  = out_word_q;
    cnt_d       = cnt_q;

    if (state_q == FLUSH) begin
      // The straddling word is waiting; once it leaves, pad the last halfword.
      if (take) begin
        out_word_d  = {CNop, res_q};
        out_valid_d = 1'b1;
        res_v_d     = 1'b0;
        state_d     = RUN;
      end
    end else if (accept) begin
      if (!res_v_q) begin
        if (comp && !in_last_i) begin
          res_d   = cval;
          res_v_d = 1'b1;
        end else begin
          out_word_d  = comp ? {CNop, cval} : in_instr_i;
          out_valid_d = 1'b1;
        end
      end else if (comp) begin
        out_word_d  = {cval, res_q};
        out_valid_d = 1'b1;
        res_v_d     = 1'b0;
      end else begin
        // Lower half completes this word, upper half becomes the new residue.
        out_word_d  = {in_instr_i[15:0], res_q};
        out_valid_d = 1'b1;
        res_d       = in_instr_i[31:16];
        if (in_last_i) begin
          state_d = FLUSH;
        end
      end

      if (comp && (cnt_q != {CntWidth{1'b1}})) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q     <= RUN;
      res_q       <= 16'h0000;
      res_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_v_q     <= res_v_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign cmp_count_o = cnt_q;

endmodule
